// File: rtl/cla_pipe_addsub_if.sv
// Operand/result handshake bundle for cla_pipe_addsub.
// Master drives operands and out_ready; slave (the adder) drives in_ready and results.
interface cla_pipe_addsub_if #(
    parameter int WIDTH = 16
);
    // Valid/ready: a beat moves on a rising edge where valid and ready are both
    // high; a producer keeps its payload stable while valid is high and unaccepted,
    // and ready may depend combinationally on the other end's state.
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ov;
    logic             zero;

    modport master (
        output in_valid, a, b, cin, sub, out_ready,
        input  in_ready, out_valid, sum, cout, ov, zero
    );

    modport slave (
        input  in_valid, a, b, cin, sub, out_ready,
        output in_ready, out_valid, sum, cout, ov, zero
    );
endinterface

// File: rtl/cla_pipe_addsub.sv
// Pipelined carry-lookahead adder/subtractor, one 4-bit group per stage, global stall.
// Define CLA_SAT_EN to saturate signed results on overflow in the last stage.
module cla_pipe_addsub #(
    parameter int WIDTH = 16
) (
    input logic              clk,
    input logic              rst_n,
    cla_pipe_addsub_if.slave bus
);
    localparam int NGRP = WIDTH / 4;
    localparam int NMID = NGRP - 1;

    generate
        if ((WIDTH % 4) != 0 || WIDTH < 8) begin : g_bad_width
            $error("cla_pipe_addsub: WIDTH must be a multiple of 4 and >= 8");
        end
    endgenerate

    // Full 4-bit lookahead: returns {c4, s[3:0]}.
    function automatic logic [4:0] cla4(input logic [3:0] x, input logic [3:0] y,
                                        input logic c0);
        logic [3:0] g;
        logic [3:0] p;
        logic       c1;
        logic       c2;
        logic       c3;
        logic       c4;
        g  = x & y;
        p  = x ^ y;
        c1 = g[0] | (p[0] & c0);
        c2 = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c0);
        c3 = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c0);
        c4 = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
           | (p[3] & p[2] & p[1] & p[0] & c0);
        return {c4, p ^ {c3, c2, c1, c0}};
    endfunction

    logic             stall;
    logic [WIDTH-1:0] b_in;
    logic             c_in;
    logic [4:0]       grp;

    // Intermediate stages 0..NGRP-2: stage k has resolved groups 0..k.
    logic             v_q [NMID];
    logic             c_q [NMID];
    logic [WIDTH-1:0] a_q [NMID];
    logic [WIDTH-1:0] b_q [NMID];
    logic [WIDTH-1:0] s_q [NMID];

    logic             v_d [NMID];
    logic             c_d [NMID];
    logic [WIDTH-1:0] a_d [NMID];
    logic [WIDTH-1:0] b_d [NMID];
    logic [WIDTH-1:0] s_d [NMID];

    logic [4:0]       fin_grp;
    logic             fin_c3;
    logic             fin_ov;
    logic [WIDTH-1:0] fin_sum;

    logic             out_valid_q;
    logic [WIDTH-1:0] sum_q;
    logic             cout_q;
    logic             ov_q;
    logic             zero_q;

    assign stall = out_valid_q & ~bus.out_ready;

    always_comb begin
        b_in = bus.sub ? ~bus.b : bus.b;
        c_in = bus.sub | bus.cin;
        grp  = cla4(bus.a[3:0], b_in[3:0], c_in);

        v_d[0] = bus.in_valid;
        c_d[0] = grp[4];
        a_d[0] = bus.a;
        b_d[0] = b_in;
        s_d[0] = {{(WIDTH-4){1'b0}}, grp[3:0]};

        for (int k = 1; k < NMID; k++) begin
            grp    = cla4(a_q[k-1][4*k +: 4], b_q[k-1][4*k +: 4], c_q[k-1]);
            v_d[k] = v_q[k-1];
            c_d[k] = grp[4];
            a_d[k] = a_q[k-1];
            b_d[k] = b_q[k-1];
            s_d[k] = s_q[k-1];
            s_d[k][4*k +: 4] = grp[3:0];
        end
    end

    // Last group: carry into the MSB is recovered from s3 = a3 ^ b3 ^ c3.
    always_comb begin
        fin_grp = cla4(a_q[NMID-1][WIDTH-1 -: 4], b_q[NMID-1][WIDTH-1 -: 4], c_q[NMID-1]);
        fin_c3  = fin_grp[3] ^ a_q[NMID-1][WIDTH-1] ^ b_q[NMID-1][WIDTH-1];
        fin_ov  = fin_c3 ^ fin_grp[4];
        fin_sum = s_q[NMID-1];
        fin_sum[WIDTH-1 -: 4] = fin_grp[3:0];
`ifdef CLA_SAT_EN
        if (fin_ov) begin
            fin_sum = a_q[NMID-1][WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                           : {1'b0, {(WIDTH-1){1'b1}}};
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NMID; k++) begin
                v_q[k] <= 1'b0;
                c_q[k] <= 1'b0;
                a_q[k] <= '0;
                b_q[k] <= '0;
                s_q[k] <= '0;
            end
            out_valid_q <= 1'b0;
            sum_q       <= '0;
            cout_q      <= 1'b0;
            ov_q        <= 1'b0;
            zero_q      <= 1'b0;
        end else if (!stall) begin
            for (int k = 0; k < NMID; k++) begin
                v_q[k] <= v_d[k];
                c_q[k] <= c_d[k];
                a_q[k] <= a_d[k];
                b_q[k] <= b_d[k];
                s_q[k] <= s_d[k];
            end
            out_valid_q <= v_q[NMID-1];
            // Result flops only load real beats, so bubbles leave the last result visible.
            if (v_q[NMID-1]) begin
                sum_q  <= fin_sum;
                cout_q <= fin_grp[4];
                ov_q   <= fin_ov;
                zero_q <= (fin_sum == '0);
            end
        end
    end

    assign bus.in_ready  = ~stall;
    assign bus.out_valid = out_valid_q;
    assign bus.sum       = sum_q;
    assign bus.cout      = cout_q;
    assign bus.ov        = ov_q;
    assign bus.zero      = zero_q;
endmodule

// File: tb/tb_cla_pipe_addsub.sv
// Scoreboard bench for cla_pipe_addsub (WIDTH=16): directed vectors plus random traffic.
// Honours CLA_SAT_EN in its expected values.
module tb_cla_pipe_addsub;
    localparam int WIDTH = 16;
    localparam int NGRP  = WIDTH / 4;
    localparam int EW    = WIDTH + 3;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    cla_pipe_addsub_if #(.WIDTH(WIDTH)) bus ();

    cla_pipe_addsub #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Scoreboard entry layout: {sum, cout, ov, zero}.
    logic [EW-1:0] exp_q[$];
    int            acc_q[$];
    int            stl_q[$];
    logic [EW-1:0] drv_exp;
    logic [EW-1:0] held;
    logic          held_v = 1'b0;
    int            n_cmp = 0;
    int            n_err = 0;
    int            cyc = 0;
    int            stall_cnt = 0;
    logic          done;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        n_cmp++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, got, want, cyc);
        end
    endtask

    // Reference: plain integer arithmetic on the operands as the spec defines them.
    function automatic logic [EW-1:0] model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                            input logic cin, input logic sub);
        logic [WIDTH-1:0] bo;
        longint           ci;
        longint           ui;
        longint           sa;
        longint           sb;
        longint           si;
        logic [WIDTH-1:0] s;
        logic             co;
        logic             ovf;
        bo  = sub ? ~b : b;
        ci  = sub ? 1 : longint'(cin);
        ui  = longint'(a) + longint'(bo) + ci;
        s   = ui[WIDTH-1:0];
        co  = ui[WIDTH];
        sa  = a[WIDTH-1]  ? longint'(a)  - (longint'(1) << WIDTH) : longint'(a);
        sb  = bo[WIDTH-1] ? longint'(bo) - (longint'(1) << WIDTH) : longint'(bo);
        si  = sa + sb + ci;
        ovf = (si > (longint'(1) << (WIDTH-1)) - 1) || (si < -(longint'(1) << (WIDTH-1)));
`ifdef CLA_SAT_EN
        if (ovf) s = (si > 0) ? {1'b0, {(WIDTH-1){1'b1}}} : {1'b1, {(WIDTH-1){1'b0}}};
`endif
        return {s, co, ovf, (s == '0)};
    endfunction

    function automatic logic [WIDTH-1:0] rand_op();
        case ($urandom_range(0, 5))
            0:       return '0;
            1:       return '1;
            2:       return 16'h7FFF;
            3:       return 16'h8000;
            default: return WIDTH'($urandom);
        endcase
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: pushes on accept, pops and compares on output transfer.
    always @(negedge clk) begin
        if (!rst_n) begin
            held_v = 1'b0;
        end else begin
            check("in_ready", 64'(bus.in_ready), 64'(!(bus.out_valid && !bus.out_ready)));
            if (held_v) begin
                check("stall_hold_valid", 64'(bus.out_valid), 64'(1));
                check("stall_hold_data", 64'({bus.sum, bus.cout, bus.ov, bus.zero}), 64'(held));
            end
            if (bus.in_valid && bus.in_ready) begin
                exp_q.push_back(drv_exp);
                acc_q.push_back(cyc);
                stl_q.push_back(stall_cnt);
            end
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_output: got sum 0x%0h with no beat outstanding (cycle %0d)",
                             bus.sum, cyc);
                end else begin
                    logic [EW-1:0] e;
                    int            acc;
                    int            stl;
                    e   = exp_q.pop_front();
                    acc = acc_q.pop_front();
                    stl = stl_q.pop_front();
                    check("result{sum,cout,ov,zero}", 64'({bus.sum, bus.cout, bus.ov, bus.zero}), 64'(e));
                    check("latency", 64'(cyc - acc), 64'(NGRP + stall_cnt - stl));
                end
            end
            if (bus.out_valid && !bus.out_ready) begin
                stall_cnt++;
                held_v = 1'b1;
                held   = {bus.sum, bus.cout, bus.ov, bus.zero};
            end else begin
                held_v = 1'b0;
            end
        end
    end

    task automatic send(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input logic cin, input logic sub, input logic [EW-1:0] e);
        int t;
        bus.in_valid = 1'b1;
        bus.a        = a;
        bus.b        = b;
        bus.cin      = cin;
        bus.sub      = sub;
        drv_exp      = e;
        t = 0;
        @(negedge clk);
        while (!bus.in_ready && t < 200) begin
            t++;
            @(negedge clk);
        end
        if (t >= 200) check("accept_timeout", 64'(0), 64'(1));
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic send_model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                              input logic cin, input logic sub);
        send(a, b, cin, sub, model(a, b, cin, sub));
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 200) begin
            @(posedge clk);
            t++;
        end
        #1;
        check("drain_empty", 64'(exp_q.size()), 64'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int s0;
        rst_n         = 1'b0;
        done          = 1'b0;
        bus.in_valid  = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.cin       = 1'b0;
        bus.sub       = 1'b0;
        bus.out_ready = 1'b1;
        drv_exp       = '0;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_out_valid", 64'(bus.out_valid), 64'(0));
        check("rst_sum", 64'(bus.sum), 64'(0));
        check("rst_flags{cout,ov,zero}", 64'({bus.cout, bus.ov, bus.zero}), 64'(0));
        check("rst_in_ready", 64'(bus.in_ready), 64'(1));
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(2);

        // Directed vectors with hand-derived results
        send(16'h1234, 16'h4321, 1'b1, 1'b0, {16'h5556, 1'b0, 1'b0, 1'b0});
`ifdef CLA_SAT_EN
        send(16'h7FFF, 16'h0001, 1'b0, 1'b0, {16'h7FFF, 1'b0, 1'b1, 1'b0});
        send(16'h8000, 16'h8000, 1'b0, 1'b0, {16'h8000, 1'b1, 1'b1, 1'b0});
        send(16'h8000, 16'h0001, 1'b0, 1'b1, {16'h8000, 1'b1, 1'b1, 1'b0});
`else
        send(16'h7FFF, 16'h0001, 1'b0, 1'b0, {16'h8000, 1'b0, 1'b1, 1'b0});
        send(16'h8000, 16'h8000, 1'b0, 1'b0, {16'h0000, 1'b1, 1'b1, 1'b1});
        send(16'h8000, 16'h0001, 1'b0, 1'b1, {16'h7FFF, 1'b1, 1'b1, 1'b0});
`endif
        send(16'h0005, 16'h0005, 1'b0, 1'b1, {16'h0000, 1'b1, 1'b0, 1'b1});
        send(16'h0000, 16'h0001, 1'b1, 1'b1, {16'hFFFF, 1'b0, 1'b0, 1'b0});
        send(16'hFFFF, 16'h0000, 1'b1, 1'b0, {16'h0000, 1'b1, 1'b0, 1'b1});
        drain();
        idle(2);

        // Eight back-to-back beats with a 3-cycle consumer stall mid-stream
        s0 = stall_cnt;
        fork
            begin
                for (int i = 0; i < 8; i++)
                    send_model(rand_op(), rand_op(), 1'($urandom), 1'(i % 2));
            end
            begin
                idle(5);
                bus.out_ready = 1'b0;
                idle(3);
                bus.out_ready = 1'b1;
            end
        join
        drain();
        check("stall_cycles", 64'(stall_cnt - s0), 64'(3));
        idle(2);

        // Reset with three beats in flight: nothing stale may emerge
        for (int i = 0; i < 3; i++)
            send_model(rand_op(), rand_op(), 1'($urandom), 1'($urandom));
        rst_n = 1'b0;
        exp_q.delete();
        acc_q.delete();
        stl_q.delete();
        @(negedge clk);
        check("midrst_out_valid", 64'(bus.out_valid), 64'(0));
        check("midrst_sum", 64'(bus.sum), 64'(0));
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(NGRP + 4);
        send(16'h1234, 16'h4321, 1'b1, 1'b0, {16'h5556, 1'b0, 1'b0, 1'b0});
        drain();

        // Random traffic: bubbles on input, random backpressure on output
        fork
            begin
                for (int i = 0; i < 300; i++) begin
                    if ($urandom_range(0, 3) == 0) idle(1);
                    else send_model(rand_op(), rand_op(), 1'($urandom), 1'($urandom));
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge clk);
                    #1;
                    bus.out_ready = ($urandom_range(0, 3) != 0);
                end
                bus.out_ready = 1'b1;
            end
        join
        drain();
        idle(4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
